// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its instruction memory,
// register file and data memory.
interface instr_sequencer_if;
    logic [4:0]  imem_addr;
    logic [15:0] imem_data;
    logic [3:0]  rf_ra1;
    logic [3:0]  rf_ra2;
    logic [7:0]  rf_rd1;
    logic [7:0]  rf_rd2;
    logic [3:0]  rf_wa;
    logic [7:0]  rf_wd;
    logic        rf_we;
    logic [3:0]  dm_ra;
    logic [7:0]  dm_rd;
    logic [3:0]  dm_wa;
    logic [7:0]  dm_wd;
    logic        dm_we;

    modport master (
        output imem_addr, rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we,
               dm_ra, dm_wa, dm_wd, dm_we,
        input  imem_data, rf_rd1, rf_rd2, dm_rd
    );

    modport slave (
        input  imem_addr, rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we,
               dm_ra, dm_wa, dm_wd, dm_we,
        output imem_data, rf_rd1, rf_rd2, dm_rd
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, WB per instruction,
// started by a single step pulse or held running by the run level.
module instr_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               run,
    instr_sequencer_if.master  bus,
    output logic [4:0]         pc,
    output logic [15:0]        ir,
    output logic               zflag,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  op;
    logic        rf_wr_op, dm_wr_op;
    logic        eq_q;
    logic [3:0]  rf_wa_q, dm_wa_q;
    logic [7:0]  rf_wd_q, dm_wd_q;

    assign op = ir[15:12];

    always_comb begin
        rf_wr_op = op inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
        dm_wr_op = op inside {4'b0000, 4'b0001};
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step || run) state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB: begin
                if (op == 4'b1111) state_nxt = HALT;
                else if (run)      state_nxt = FETCH;
                else               state_nxt = IDLE;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: reset is synchronous; every architectural register is cleared so
    // an aborted instruction leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= '0;
            ir      <= '0;
            zflag   <= 1'b0;
            eq_q    <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            dm_wa_q <= '0;
            dm_wd_q <= '0;
        end else begin
            case (state)
                FETCH: ir <= bus.imem_data;
                EXEC: begin
                    case (op)
                        4'b0000: begin dm_wa_q <= ir[7:4];  dm_wd_q <= bus.rf_rd2; end
                        4'b0001: begin dm_wa_q <= ir[11:8]; dm_wd_q <= ir[7:0];    end
                        4'b0010: begin rf_wa_q <= ir[7:4];  rf_wd_q <= bus.dm_rd;  end
                        4'b0011: begin rf_wa_q <= ir[11:8]; rf_wd_q <= ir[7:0];    end
                        4'b0100,
                        4'b0101: begin
                            rf_wa_q <= ir[11:8];
                            rf_wd_q <= bus.rf_rd1 + bus.rf_rd2;
                        end
                        4'b1000,
                        4'b1001: eq_q <= (bus.rf_rd1 == bus.rf_rd2);
                        default: ;
                    endcase
                end
                WB: begin
                    if (op[3:1] == 3'b100) zflag <= eq_q;
                    // Branch target is the low five bits above the byte field.
                    if (op[3:1] == 3'b101)  pc <= zflag ? ir[12:8] : pc + 5'd1;
                    else if (op != 4'b1111) pc <= pc + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Enables are decoded from WB and gated by reset so an aborted WB never writes.
    assign bus.rf_we     = rst_n && (state == WB) && rf_wr_op;
    assign bus.dm_we     = rst_n && (state == WB) && dm_wr_op;
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.dm_wa     = dm_wa_q;
    assign bus.dm_wd     = dm_wd_q;
    assign bus.imem_addr = pc;
    assign bus.rf_ra1    = ir[7:4];
    assign bus.rf_ra2    = ir[3:0];
    assign bus.dm_ra     = ir[3:0];

    assign busy   = state inside {FETCH, DECODE, EXEC, WB};
    assign halted = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table of single-step
// instructions plus hand-written run, branch, wrap, halt and reset sequences.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic       run = 1'b0;
    logic [4:0] pc;
    logic [15:0] ir;
    logic       zflag, busy, halted;

    instr_sequencer_if sif ();

    instr_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (step),
        .run    (run),
        .bus    (sif.master),
        .pc     (pc),
        .ir     (ir),
        .zflag  (zflag),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [32];
    logic [7:0]  rf   [16];
    logic [7:0]  dm   [16];

    assign sif.imem_data = imem[sif.imem_addr];
    assign sif.rf_rd1    = rf[sif.rf_ra1];
    assign sif.rf_rd2    = rf[sif.rf_ra2];
    assign sif.dm_rd     = dm[sif.dm_ra];

    always @(posedge clk) begin
        if (sif.rf_we) rf[sif.rf_wa] = sif.rf_wd;
        if (sif.dm_we) dm[sif.dm_wa] = sif.dm_wd;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         rf_we_cnt = 0, dm_we_cnt = 0, excl_err = 0;
    int         rf_we_cyc = 0, dm_we_cyc = 0;
    logic [3:0] rf_wa_seen = '0, dm_wa_seen = '0;
    logic [7:0] rf_wd_seen = '0, dm_wd_seen = '0;

    always @(negedge clk) begin
        if (sif.rf_we) begin
            rf_we_cnt++;
            rf_wa_seen = sif.rf_wa;
            rf_wd_seen = sif.rf_wd;
            rf_we_cyc  = cyc;
        end
        if (sif.dm_we) begin
            dm_we_cnt++;
            dm_wa_seen = sif.dm_wa;
            dm_wd_seen = sif.dm_wd;
            dm_we_cyc  = cyc;
        end
        if (sif.rf_we && sif.dm_we) excl_err++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 32; i++) imem[i] = 16'hF000;
        for (int i = 0; i < 16; i++) begin
            rf[i] = 8'(i * 17);
            dm[i] = 8'(8'hA0 + i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step  = 1'b0;
        run   = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic step_pulse();
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(5);
    endtask

    typedef struct {
        logic [15:0] instr;
        int          rf_n;
        logic [3:0]  rwa;
        logic [7:0]  rwd;
        int          dm_n;
        logic [3:0]  dwa;
        logic [7:0]  dwd;
        logic [4:0]  pc;
        logic        z;
        logic        h;
    } vec_t;

    vec_t vt [11];

    initial begin
        int brf, bdm, scyc;

        // R[i] = i*0x11, DM[i] = 0xA0+i, single step from pc 0
        vt[0]  = '{16'h3205, 1, 4'd2, 8'h05, 0, 4'd0, 8'h00, 5'd1, 1'b0, 1'b0};
        vt[1]  = '{16'h0023, 0, 4'd0, 8'h00, 1, 4'd2, 8'h33, 5'd1, 1'b0, 1'b0};
        vt[2]  = '{16'h17C4, 0, 4'd0, 8'h00, 1, 4'd7, 8'hC4, 5'd1, 1'b0, 1'b0};
        vt[3]  = '{16'h2056, 1, 4'd5, 8'hA6, 0, 4'd0, 8'h00, 5'd1, 1'b0, 1'b0};
        vt[4]  = '{16'h4312, 1, 4'd3, 8'h33, 0, 4'd0, 8'h00, 5'd1, 1'b0, 1'b0};
        vt[5]  = '{16'h59AB, 1, 4'd9, 8'h65, 0, 4'd0, 8'h00, 5'd1, 1'b0, 1'b0};
        vt[6]  = '{16'h6000, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 5'd1, 1'b0, 1'b0};
        vt[7]  = '{16'h8045, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 5'd1, 1'b0, 1'b0};
        vt[8]  = '{16'h9044, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 5'd1, 1'b1, 1'b0};
        vt[9]  = '{16'hA900, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 5'd1, 1'b0, 1'b0};
        vt[10] = '{16'hF000, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 5'd0, 1'b0, 1'b1};

        init_mem();
        do_reset();
        check("rst_pc",     32'(pc), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_halted", 32'(halted), 0);

        foreach (vt[i]) begin
            do_reset();
            init_mem();
            imem[0] = vt[i].instr;
            brf = rf_we_cnt;
            bdm = dm_we_cnt;
            step = 1'b1;
            tick(1);
            step = 1'b0;
            scyc = cyc;
            check($sformatf("v%0d_busy_fetch", i), 32'(busy), 1);
            tick(5);
            check($sformatf("v%0d_rf_we_n", i), 32'(rf_we_cnt - brf), 32'(vt[i].rf_n));
            check($sformatf("v%0d_dm_we_n", i), 32'(dm_we_cnt - bdm), 32'(vt[i].dm_n));
            if (vt[i].rf_n == 1) begin
                check($sformatf("v%0d_rf_wa", i), 32'(rf_wa_seen), 32'(vt[i].rwa));
                check($sformatf("v%0d_rf_wd", i), 32'(rf_wd_seen), 32'(vt[i].rwd));
                check($sformatf("v%0d_rf_lat", i), 32'(rf_we_cyc - scyc), 3);
            end
            if (vt[i].dm_n == 1) begin
                check($sformatf("v%0d_dm_wa", i), 32'(dm_wa_seen), 32'(vt[i].dwa));
                check($sformatf("v%0d_dm_wd", i), 32'(dm_wd_seen), 32'(vt[i].dwd));
                check($sformatf("v%0d_dm_lat", i), 32'(dm_we_cyc - scyc), 3);
            end
            check($sformatf("v%0d_pc", i),     32'(pc), 32'(vt[i].pc));
            check($sformatf("v%0d_zflag", i),  32'(zflag), 32'(vt[i].z));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vt[i].h));
            check($sformatf("v%0d_busy", i),   32'(busy), 0);
            check($sformatf("v%0d_ir", i),     32'(ir), 32'(vt[i].instr));
        end

        // Reset from a dirty state clears all registers and outputs
        rst_n = 1'b0;
        tick(1);
        check("rst2_ir",    32'(ir), 0);
        check("rst2_rf_wa", 32'(sif.rf_wa), 0);
        check("rst2_rf_wd", 32'(sif.rf_wd), 0);
        check("rst2_halted", 32'(halted), 0);
        check("rst2_we",    32'({sif.rf_we, sif.dm_we}), 0);
        rst_n = 1'b1;

        // Run: add with carry dropped, then halt; halt ignores step and run
        do_reset();
        init_mem();
        rf[1] = 8'hF0;
        rf[2] = 8'h20;
        imem[0] = 16'h4312;
        imem[1] = 16'hF000;
        brf = rf_we_cnt;
        run = 1'b1;
        tick(12);
        run = 1'b0;
        check("run_rf_we_n", 32'(rf_we_cnt - brf), 1);
        check("run_rf_wa",   32'(rf_wa_seen), 3);
        check("run_rf_wd",   32'(rf_wd_seen), 32'h10);
        check("run_halted",  32'(halted), 1);
        check("run_busy",    32'(busy), 0);
        check("run_pc",      32'(pc), 1);
        step_pulse();
        run = 1'b1;
        tick(6);
        run = 1'b0;
        check("halt_hold",      32'(halted), 1);
        check("halt_hold_pc",   32'(pc), 1);
        check("halt_hold_busy", 32'(busy), 0);

        // Compare then branch: taken with equal operands, not taken otherwise
        do_reset();
        init_mem();
        rf[4] = 8'h07;
        rf[5] = 8'h07;
        imem[0] = 16'h8045;
        imem[1] = 16'hA900;
        run = 1'b1;
        tick(16);
        run = 1'b0;
        check("br_taken_pc", 32'(pc), 9);
        check("br_taken_z",  32'(zflag), 1);
        check("br_taken_h",  32'(halted), 1);

        do_reset();
        init_mem();
        rf[4] = 8'h07;
        rf[5] = 8'h08;
        imem[0] = 16'h8045;
        imem[1] = 16'hA900;
        run = 1'b1;
        tick(16);
        run = 1'b0;
        check("br_not_pc", 32'(pc), 2);
        check("br_not_z",  32'(zflag), 0);

        // Branch to 31, then a NOP there wraps pc to 0
        do_reset();
        init_mem();
        imem[0]  = 16'h8000;
        imem[1]  = 16'hBF00;
        imem[31] = 16'h6000;
        step_pulse();
        step_pulse();
        check("wrap_pc31", 32'(pc), 31);
        step_pulse();
        check("wrap_pc0",  32'(pc), 0);

        // step+run together start once; a step while busy is dropped
        do_reset();
        init_mem();
        imem[0] = 16'h3205;
        imem[1] = 16'h3306;
        brf = rf_we_cnt;
        step = 1'b1;
        run  = 1'b1;
        tick(1);
        step = 1'b0;
        run  = 1'b0;
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(8);
        check("one_start_we_n", 32'(rf_we_cnt - brf), 1);
        check("one_start_pc",   32'(pc), 1);

        // Reset in EXEC aborts a data-memory store
        do_reset();
        init_mem();
        imem[0] = 16'h1A3C;
        bdm = dm_we_cnt;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("abort_busy",  32'(busy), 0);
        check("abort_pc",    32'(pc), 0);
        check("abort_dm_wa", 32'(sif.dm_wa), 0);
        check("abort_dm_wd", 32'(sif.dm_wd), 0);
        rst_n = 1'b1;
        tick(6);
        check("abort_dm_we_n", 32'(dm_we_cnt - bdm), 0);
        check("abort_idle",    32'(busy), 0);

        // Reset wins over step and run on the same edge
        rst_n = 1'b0;
        step  = 1'b1;
        run   = 1'b1;
        tick(1);
        check("rst_prio_busy", 32'(busy), 0);
        step  = 1'b0;
        run   = 1'b0;
        rst_n = 1'b1;
        tick(1);
        check("rst_prio_idle", 32'(busy), 0);

        check("we_exclusive", 32'(excl_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
